demux_1to2_buf: RTL and testbench
=================================

DEMUX_1TO2_BUF -- requirements
Module: demux_1to2_buf

Interface
REQ-001 Parameter N, default 32: data width in bits of the input word and of each output word.
REQ-002 Parameter DEPTH, fixed at 2: entries per output channel buffer; no other value is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstb  input  1  asynchronous, active-low reset.
REQ-005 X  input  N  input data word.
REQ-006 x_valid  input  1  X and S are valid this cycle.
REQ-007 S  input  1  destination select: 0 routes to channel 0, 1 routes to channel 1; sampled only when x_valid=1.
REQ-008 x_ready  output  1  block accepts X this cycle.
REQ-009 Y0 / Y1  output  N each  head-of-buffer data, channel 0 / channel 1.
REQ-010 y0_valid / y1_valid  output  1 each  the channel buffer is non-empty.
REQ-011 y0_ready / y1_ready  input  1 each  the downstream consumer takes the head word.
REQ-012 cnt0 / cnt1  output  8 each  count of words accepted into channel 0 / channel 1, modulo 256.

Function
REQ-013 An input transfer SHALL occur on a rising edge with x_valid=1 and x_ready=1; X SHALL be written to the tail of the buffer selected by S.
REQ-014 x_ready SHALL equal 1 exactly when the buffer selected by the current S holds fewer than 2 entries, whatever the state of y*_ready.
- x_ready is combinational from S and the buffer occupancy.
- A full destination SHALL NOT accept a word in the same cycle it drains one.
REQ-015 x_ready SHALL NOT depend on x_valid.
REQ-016 An output transfer on channel k SHALL occur on a rising edge with yk_valid=1 and yk_ready=1; the head entry SHALL be removed.
REQ-017 Latency: a word accepted into an empty buffer SHALL appear on Yk with yk_valid=1 in the next cycle; there is no combinational path from X to Yk.
REQ-018 Each buffer SHALL be strictly FIFO: words leave channel k in the order they were accepted into channel k.
REQ-019 A simultaneous push and pop on the same channel with occupancy 1 SHALL leave occupancy at 1, with the new word at the head after the edge.
REQ-020 A simultaneous push and pop on the same channel with occupancy 0 SHALL NOT occur, because the pop requires yk_valid=1.
REQ-021 Pushes to one channel and pops from the other channel in the same cycle SHALL proceed independently.
REQ-022 Yk SHALL hold its value while yk_valid=1 and yk_ready=0 (stable under backpressure).
REQ-023 Yk SHALL be all zeros whenever yk_valid=0.
REQ-024 cntk SHALL increment by 1 on each input transfer into channel k and wrap from 255 to 0.
REQ-025 Changes on S while x_valid=0 SHALL have no effect on state.

Reset
REQ-026 While rstb=0, regardless of clk, all of the following SHALL hold:
- both buffers are empty;
- y0_valid=y1_valid=0;
- Y0=Y1=0;
- cnt0=cnt1=0;
- x_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words without emitting them.
REQ-028 The first transfer after reset SHALL be possible on the first rising edge with rstb=1.
REQ-029 rstb deassertion is synchronised externally; the block requires no internal synchroniser.

Verification
REQ-030 Routing: N=32, all y*_ready=1; drive X=0xA5A5A5A5 with S=0, then X=0x5A5A5A5A with S=1.
- Y0=0xA5A5A5A5 with y0_valid=1 one cycle after the first word.
- Y1=0x5A5A5A5A one cycle after the second word.
- cnt0=1, cnt1=1.
REQ-031 Fill and backpressure: y0_ready=0; push 0x1, 0x2, 0x3 to S=0.
- The first two words are accepted.
- x_ready=0 on the third; Y0 holds 0x1.
- Raise y0_ready: outputs 0x1, then 0x2, then 0x3 after it is accepted.
REQ-032 Cross-channel independence: channel 0 full with y0_ready=0; push 0x7 with S=1.
- Accepted with x_ready=1; Y1=0x7 on the next cycle.
REQ-033 Simultaneous push/pop: channel 1 holds 0x10 with y1_ready=1; push 0x11 to S=1 in the same cycle.
- Occupancy stays 1; Y1=0x11 after the edge.
REQ-034 Counter wrap: 256 accepted pushes to channel 0 -> cnt0 returns to 0; cnt1 unchanged.
REQ-035 Mid-operation reset: assert rstb=0 with both buffers full.
- Immediately, without a clock edge: y0_valid=y1_valid=0, Y0=Y1=0, cnt0=cnt1=0, x_ready=1.
- After release, no stale words are emitted.

Source files
------------

// File: rtl/demux_1to2_buf.sv
// rtl/demux_1to2_buf.sv - 1-to-2 demultiplexer with a 2-entry FIFO and an accept counter per channel
// A full channel never accepts a word, even in a cycle where it drains one.

module demux_1to2_buf_fifo2 #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         i_push,
  input  logic [N-1:0] i_data,
  input  logic         i_pop,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);
  logic [N-1:0] r_mem [2];
  logic         r_head;
  logic [1:0]   r_count;
  logic         w_wr_ptr;

  // Tail slot is head+count mod 2; pushes are never issued when full.
  assign w_wr_ptr = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'(DEPTH));
  assign o_data  = o_valid ? r_mem[r_head] : '0;
endmodule

module demux_1to2_buf #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [N-1:0] X,
  input  logic         x_valid,
  input  logic         S,
  output logic         x_ready,
  output logic [N-1:0] Y0,
  output logic [N-1:0] Y1,
  output logic         y0_valid,
  output logic         y1_valid,
  input  logic         y0_ready,
  input  logic         y1_ready,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
);
  logic       w_full0;
  logic       w_full1;
  logic       w_push0;
  logic       w_push1;
  logic       w_pop0;
  logic       w_pop1;
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  assign x_ready = S ? ~w_full1 : ~w_full0;
  assign w_push0 = x_valid & x_ready & ~S;
  assign w_push1 = x_valid & x_ready & S;
  assign w_pop0  = y0_valid & y0_ready;
  assign w_pop1  = y1_valid & y1_ready;

  demux_1to2_buf_fifo2 #(.N(N), .DEPTH(DEPTH)) u_ch0 (
    .clk     (clk),
    .rstb    (rstb),
    .i_push  (w_push0),
    .i_data  (X),
    .i_pop   (w_pop0),
    .o_data  (Y0),
    .o_valid (y0_valid),
    .o_full  (w_full0)
  );

  demux_1to2_buf_fifo2 #(.N(N), .DEPTH(DEPTH)) u_ch1 (
    .clk     (clk),
    .rstb    (rstb),
    .i_push  (w_push1),
    .i_data  (X),
    .i_pop   (w_pop1),
    .o_data  (Y1),
    .o_valid (y1_valid),
    .o_full  (w_full1)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_push0) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_push1) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb/tb_demux_1to2_buf.sv - self-checking bench for demux_1to2_buf against a queue-based channel model
module tb_demux_1to2_buf;
  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] X;
  logic        x_valid;
  logic        S;
  logic        x_ready;
  logic [31:0] Y0;
  logic [31:0] Y1;
  logic        y0_valid;
  logic        y1_valid;
  logic        y0_ready;
  logic        y1_ready;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [7:0]  m_cnt0;
  logic [7:0]  m_cnt1;

  demux_1to2_buf #(.N(32), .DEPTH(2)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .X        (X),
    .x_valid  (x_valid),
    .S        (S),
    .x_ready  (x_ready),
    .Y0       (Y0),
    .Y1       (Y1),
    .y0_valid (y0_valid),
    .y1_valid (y1_valid),
    .y0_ready (y0_ready),
    .y1_ready (y1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".y0_valid"}, {31'd0, y0_valid}, {31'd0, q0.size() > 0});
    check({tag, ".y1_valid"}, {31'd0, y1_valid}, {31'd0, q1.size() > 0});
    check({tag, ".Y0"}, Y0, (q0.size() > 0) ? q0[0] : 32'd0);
    check({tag, ".Y1"}, Y1, (q1.size() > 0) ? q1[0] : 32'd0);
    check({tag, ".cnt0"}, {24'd0, cnt0}, {24'd0, m_cnt0});
    check({tag, ".cnt1"}, {24'd0, cnt1}, {24'd0, m_cnt1});
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_cnt0 = 8'd0;
    m_cnt1 = 8'd0;
  endtask

  // One clock cycle: apply inputs, check x_ready, advance model across the edge, check outputs.
  task automatic step(input logic xv, input logic s, input logic [31:0] x,
                      input logic r0, input logic r1);
    logic push0, push1, pop0, pop1;
    X = x; x_valid = xv; S = s; y0_ready = r0; y1_ready = r1;
    #1;
    check("x_ready", {31'd0, x_ready}, {31'd0, (s ? q1.size() : q0.size()) < 2});
    push0 = xv && !s && (q0.size() < 2);
    push1 = xv && s && (q1.size() < 2);
    pop0  = r0 && (q0.size() > 0);
    pop1  = r1 && (q1.size() > 0);
    @(posedge clk);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (push0) begin q0.push_back(x); m_cnt0 = m_cnt0 + 8'd1; end
    if (push1) begin q1.push_back(x); m_cnt1 = m_cnt1 + 8'd1; end
    #1;
    check_outputs("step");
  endtask

  initial begin
    rstb = 1'b0; X = '0; x_valid = 1'b0; S = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    model_reset();
    #3;
    check("rst.x_ready", {31'd0, x_ready}, 32'd1);
    check_outputs("rst");

    @(negedge clk);
    rstb = 1'b1;
    // routing, with the first push on the very first edge after reset
    step(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1);
    check("route.Y0", Y0, 32'hA5A5A5A5);
    check("route.y0_valid", {31'd0, y0_valid}, 32'd1);
    step(1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1);
    check("route.Y1", Y1, 32'h5A5A5A5A);
    check("route.cnt0", {24'd0, cnt0}, 32'd1);
    check("route.cnt1", {24'd0, cnt1}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // fill and backpressure on channel 0
    step(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
    check("fill.x_ready", {31'd0, x_ready}, 32'd0);
    check("fill.Y0_hold", Y0, 32'h1);
    step(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
    check("fill.Y0_second", Y0, 32'h2);
    step(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
    check("fill.Y0_third", Y0, 32'h3);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("fill.drained", {31'd0, y0_valid}, 32'd0);

    // cross-channel independence
    step(1'b1, 1'b0, 32'hC0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h7, 1'b0, 1'b0);
    check("cross.Y1", Y1, 32'h7);
    check("cross.Y0", Y0, 32'hC0);
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b1);

    // simultaneous push/pop at occupancy 1
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h11, 1'b0, 1'b1);
    check("pushpop.Y1", Y1, 32'h11);
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    check("pushpop.occ1", {31'd0, y1_valid}, 32'd0);

    // both channels full, then reset between edges
    step(1'b1, 1'b1, 32'hD0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hD1, 1'b0, 1'b0);
    #2;
    rstb = 1'b0;
    #1;
    model_reset();
    check("midrst.x_ready", {31'd0, x_ready}, 32'd1);
    check("midrst.Y0", Y0, 32'd0);
    check("midrst.Y1", Y1, 32'd0);
    check("midrst.cnt0", {24'd0, cnt0}, 32'd0);
    check_outputs("midrst");
    @(negedge clk);
    rstb = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("midrst.no_stale0", {31'd0, y0_valid}, 32'd0);
    check("midrst.no_stale1", {31'd0, y1_valid}, 32'd0);

    // counter wrap on channel 0
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("wrap.cnt0", {24'd0, cnt0}, 32'd0);
    check("wrap.cnt1", {24'd0, cnt1}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
